timer_sequencer: RTL and testbench

- Initiator for the seconds-counter handshake: drives start and counterSeconds into the counter, then consumes countInProcess and signal from it.
- Runs a programmable list of NUM_PHASES timed phases back-to-back, e.g. door-open, dwell, door-close in a lab controller.
- Reports phase progress, completion and a stalled-counter error to top-level control logic.

---
 rtl/timer_sequencer_pkg.sv | 14 +
 rtl/timer_sequencer_phase_mux.sv | 21 ++
 rtl/timer_sequencer.sv | 151 +++++++++++++++
 tb/tb_timer_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sequencer_pkg.sv
// rtl/timer_sequencer_pkg.sv - shared state encoding and default widths for timer_sequencer
package timer_sequencer_pkg;

  // Default duration width, matching the counter's counterSeconds field.
  localparam int DEFAULT_W = 10;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

endpackage

// File: rtl/timer_sequencer_phase_mux.sv
// rtl/timer_sequencer_phase_mux.sv - selects one W-bit duration out of a packed phase list
//   i_bus : N packed durations, entry 0 in bits [W-1:0]
//   i_sel : phase index; indices >= N select 0
//   o_dur : selected duration
module timer_sequencer_phase_mux #(
  parameter int N = 3,
  parameter int W = 10
) (
  input  logic [N*W-1:0] i_bus,
  input  logic [2:0]     i_sel,
  output logic [W-1:0]   o_dur
);

  always_comb begin
    o_dur = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == 3'(k)) o_dur = i_bus[k*W +: W];
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - runs NUM_PHASES timed phases back-to-back through a seconds counter
//   clk, reset        : clock, asynchronous active-low reset
//   go, abort         : run request (IDLE only), synchronous abort to IDLE
//   phaseSeconds      : packed phase durations, latched on go
//   countInProcess    : counter busy counting down
//   signal            : counter end-of-count pulse
//   start             : one-cycle load pulse to the counter
//   counterSeconds    : duration of the current phase
//   phase             : active phase index
//   busy, phaseDone   : running flag, one pulse per completed phase
//   done, error       : sequence-complete pulse, stalled-counter flag
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int NUM_PHASES  = 3,
  parameter int W           = DEFAULT_W,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  abort,
  input  logic [NUM_PHASES*W-1:0] phaseSeconds,
  input  logic                  countInProcess,
  input  logic                  signal,
  output logic                  start,
  output logic [W-1:0]          counterSeconds,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  phaseDone,
  output logic                  done,
  output logic                  error
);

  localparam int              AW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]      LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [AW-1:0]   ACK_LIMIT  = AW'(ACK_TIMEOUT);

  logic [2:0]              r_state;
  logic [2:0]              r_phase;
  logic [NUM_PHASES*W-1:0] r_dur;
  logic [W-1:0]            r_counter_seconds;
  logic [AW-1:0]           r_ack_cnt;
  logic                    r_phase_done;

  logic [2:0]              w_next_state;
  logic [2:0]              w_next_phase;
  logic                    w_complete;
  logic                    w_is_last;
  logic                    w_ack_expired;
  logic [NUM_PHASES*W-1:0] w_mux_bus;
  logic [W-1:0]            w_next_dur;

  assign w_is_last     = (r_phase == LAST_PHASE);
  assign w_ack_expired = ((r_ack_cnt + AW'(1)) >= ACK_LIMIT);

  // counterSeconds is loaded on entry to ISSUE, so the mux looks up the
  // phase we are about to be in. On go the latch happens at the same edge,
  // so the raw input bus is used while still in IDLE.
  assign w_mux_bus = (r_state == S_IDLE) ? phaseSeconds : r_dur;

  timer_sequencer_phase_mux #(
    .N (NUM_PHASES),
    .W (W)
  ) u_phase_mux (
    .i_bus (w_mux_bus),
    .i_sel (w_next_phase),
    .o_dur (w_next_dur)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_next_state = S_ISSUE;
          w_next_phase = '0;
        end
      end
      S_ISSUE: begin
        // A zero duration in counterSeconds means this phase is skipped.
        if (r_counter_seconds == '0) begin
          if (w_is_last) w_next_state = S_FINISH;
          else           w_next_phase = r_phase + 3'd1;
        end else begin
          w_next_state = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (signal)              w_complete   = 1'b1;
        else if (countInProcess) w_next_state = S_WAIT_DONE;
        else if (w_ack_expired)  w_next_state = S_ERROR;
      end
      S_WAIT_DONE: begin
        if (signal) w_complete = 1'b1;
      end
      S_FINISH: w_next_state = S_IDLE;
      S_ERROR:  w_next_state = S_ERROR;
      default:  w_next_state = S_IDLE;
    endcase

    if (w_complete) begin
      if (w_is_last) begin
        w_next_state = S_FINISH;
      end else begin
        w_next_state = S_ISSUE;
        w_next_phase = r_phase + 3'd1;
      end
    end

    // Abort wins over everything; phase keeps its value for inspection.
    if (abort) begin
      w_next_state = S_IDLE;
      w_next_phase = r_phase;
      w_complete   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_phase           <= '0;
      r_dur             <= '0;
      r_counter_seconds <= '0;
      r_ack_cnt         <= '0;
      r_phase_done      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_phase      <= w_next_phase;
      r_phase_done <= w_complete;
      if (r_state == S_IDLE && go && !abort) r_dur <= phaseSeconds;
      if (w_next_state == S_ISSUE) r_counter_seconds <= w_next_dur;
      if (r_state == S_ISSUE) begin
        r_ack_cnt <= '0;
      end else if (r_state == S_WAIT_ACK && r_ack_cnt != ACK_LIMIT) begin
        r_ack_cnt <= r_ack_cnt + AW'(1);
      end
    end
  end

  assign start          = (r_state == S_ISSUE) && (r_counter_seconds != '0);
  assign counterSeconds = r_counter_seconds;
  assign phase          = r_phase;
  assign busy           = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign phaseDone      = r_phase_done;
  assign done           = (r_state == S_FINISH);
  assign error          = (r_state == S_ERROR);

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - self-checking bench for timer_sequencer
module tb_timer_sequencer;

  localparam int NUM = 3;
  localparam int W   = 10;
  localparam int ACK = 4;
  localparam int PW  = NUM * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          abort;
  logic [PW-1:0] phaseSeconds;
  logic          countInProcess;
  logic          signal;
  logic          start;
  logic [W-1:0]  counterSeconds;
  logic [2:0]    phase;
  logic          busy;
  logic          phaseDone;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int dur[NUM];

  timer_sequencer #(
    .NUM_PHASES  (NUM),
    .W           (W),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .abort          (abort),
    .phaseSeconds   (phaseSeconds),
    .countInProcess (countInProcess),
    .signal         (signal),
    .start          (start),
    .counterSeconds (counterSeconds),
    .phase          (phase),
    .busy           (busy),
    .phaseDone      (phaseDone),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $error("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_durs();
    for (int i = 0; i < NUM; i++) phaseSeconds[i*W +: W] = W'(dur[i]);
  endtask

  // Number of consecutive zero-length phases starting at idx.
  function automatic int skip_from(input int idx);
    int z = 0;
    while (idx + z < NUM && dur[idx + z] == 0) z++;
    return z;
  endfunction

  // Plays the counter for one full sequence. Expected timing comes from the
  // rules: a go/signal seen at an edge yields the next start (or done) one
  // cycle later plus one cycle per skipped zero phase; phaseDone one cycle
  // after each signal; start values are the nonzero durations in order.
  task automatic run_seq(input int fixed_a, input bit direct);
    int nxt, z, a, nz, starts, budget, g_cyc;
    int exp_start, exp_done, exp_pd, sig_cyc, cip_from;
    load_durs();
    nz = 0;
    for (int i = 0; i < NUM; i++) if (dur[i] != 0) nz++;
    go = 1'b1;
    g_cyc = cyc;
    exp_start = -1; exp_done = -1; exp_pd = -1; sig_cyc = -1; cip_from = -1;
    starts = 0;
    z = skip_from(0);
    nxt = z;
    if (z < NUM) exp_start = cyc + 1 + z;
    else         exp_done  = cyc + 1 + z;
    budget = cyc + 200;
    while (cyc <= budget && !(exp_done >= 0 && cyc > exp_done)) begin
      tick();
      phaseSeconds = PW'($urandom);
      chk1("start", start, cyc == exp_start);
      chk1("phaseDone", phaseDone, cyc == exp_pd);
      chk1("done", done, cyc == exp_done);
      chk1("busy", busy, cyc > g_cyc && (exp_done < 0 || cyc <= exp_done));
      chk1("error", error, 1'b0);
      if (cyc == exp_start) begin
        chkv("counterSeconds", 32'(counterSeconds), dur[nxt]);
        chkv("phase", 32'(phase), nxt);
        starts++;
        a = (fixed_a != 0) ? fixed_a : int'($urandom_range(ACK, 1));
        if (direct) begin
          cip_from = -1;
          sig_cyc  = cyc + 1;
        end else begin
          cip_from = cyc + a;
          sig_cyc  = cip_from + int'($urandom_range(4, 1));
        end
      end
      countInProcess = (cip_from >= 0 && cyc >= cip_from && cyc < sig_cyc);
      signal         = (cyc == sig_cyc);
      go             = (sig_cyc > cyc) ? 1'($urandom_range(1, 0)) : 1'b0;
      if (signal) begin
        exp_pd = cyc + 1;
        nxt++;
        z = skip_from(nxt);
        if (nxt + z < NUM) begin
          nxt += z;
          exp_start = cyc + 1 + z;
        end else begin
          exp_done = cyc + 1 + z;
        end
      end
    end
    checks++;
    assert (cyc <= budget) else begin
      errors++;
      $error("FAIL seq_timeout: observed=%0d expected<=%0d", cyc, budget);
    end
    chkv("start_count", starts, nz);
    go = 1'b0; countInProcess = 1'b0; signal = 1'b0;
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; abort = 1'b0;
    countInProcess = 1'b0; signal = 1'b0; phaseSeconds = '0;
    #12;
    chk1("rst_start", start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_phaseDone", phaseDone, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chkv("rst_phase", 32'(phase), 0);
    chkv("rst_counterSeconds", 32'(counterSeconds), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic sequence, counter acknowledges one cycle after start.
    dur = '{5, 3, 2};
    run_seq(1, 1'b0);

    // Middle phase skipped.
    dur = '{4, 0, 6};
    run_seq(0, 1'b0);

    // Counter answers with signal alone, go held randomly while busy.
    dur = '{2, 7, 1};
    run_seq(0, 1'b1);

    // Counter never answers: ack timeout into ERROR.
    dur = '{3, 1, 1};
    load_durs();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk1("to_start", start, 1'b1);
    for (int i = 1; i <= ACK; i++) begin
      tick();
      chk1("to_no_error_yet", error, 1'b0);
      chk1("to_busy_waiting", busy, 1'b1);
    end
    tick();
    chk1("to_error", error, 1'b1);
    chk1("to_busy", busy, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk1("err_go_start", start, 1'b0);
    chk1("err_go_busy", busy, 1'b0);
    chk1("err_go_error", error, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort_clr_error", error, 1'b0);
    chk1("abort_clr_busy", busy, 1'b0);
    chk1("abort_clr_start", start, 1'b0);

    // Abort during WAIT_DONE of phase 1, with a coincident signal.
    dur = '{3, 5, 2};
    load_durs();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk1("ab_start0", start, 1'b1);
    tick();
    signal = 1'b1;
    tick();
    signal = 1'b0;
    chk1("ab_pd0", phaseDone, 1'b1);
    chk1("ab_start1", start, 1'b1);
    chkv("ab_cs1", 32'(counterSeconds), 5);
    tick();
    countInProcess = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    signal = 1'b1;
    tick();
    abort = 1'b0; signal = 1'b0; countInProcess = 1'b0;
    chk1("ab_busy", busy, 1'b0);
    chkv("ab_phase", 32'(phase), 1);
    chk1("ab_done", done, 1'b0);
    chk1("ab_pd", phaseDone, 1'b0);
    chk1("ab_start", start, 1'b0);
    tick();
    chk1("ab_idle_start", start, 1'b0);
    chk1("ab_idle_done", done, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk1("ab_restart", start, 1'b1);
    chkv("ab_restart_phase", 32'(phase), 0);
    chkv("ab_restart_cs", 32'(counterSeconds), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("ab_clean", busy, 1'b0);

    // Asynchronous reset in the middle of phase 1.
    dur = '{1, 6, 6};
    load_durs();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    signal = 1'b1;
    tick();
    signal = 1'b0;
    chk1("ar_start1", start, 1'b1);
    tick();
    countInProcess = 1'b1;
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk1("ar_start", start, 1'b0);
    chk1("ar_busy", busy, 1'b0);
    chkv("ar_phase", 32'(phase), 0);
    chkv("ar_cs", 32'(counterSeconds), 0);
    chk1("ar_done", done, 1'b0);
    chk1("ar_pd", phaseDone, 1'b0);
    chk1("ar_error", error, 1'b0);
    #2;
    reset = 1'b1;
    countInProcess = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("ar_post_start", start, 1'b0);
      chk1("ar_post_busy", busy, 1'b0);
    end

    // Randomized sequences.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NUM; i++) begin
        dur[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(1023, 1));
      end
      run_seq(0, 1'($urandom_range(1, 0)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
